// File: rtl/udm_dbus_pkg.sv
// Shared types and constants for the memsplit DLX data-bus arbiter.
package udm_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  localparam logic M_CPU = 1'b0;
  localparam logic M_UDM = 1'b1;

endpackage

// File: rtl/udm_rr_arb2.sv
// Two-input winner select: round-robin (mode=0) or fixed priority to input 0 (mode=1).
module udm_rr_arb2
  import udm_dbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       mode,
  input  logic       update,
  input  logic       grant,
  output logic       winner
);

  logic last_grant;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= M_UDM;
    end else if (update) begin
      last_grant <= grant;
    end
  end

  // Input 1 wins when it is the only requester, or on contention in round-robin mode
  // when input 0 was the last one served.
  always_comb begin
    winner = req[1] && (!req[0] || (!mode && (last_grant == M_CPU)));
  end

endmodule

// File: rtl/udm_dbus_arbiter.sv
// Two-master, one-slave data-bus arbiter: one outstanding read, response routing,
// and a read-response timeout that answers with a poison word.
module udm_dbus_arbiter
  import udm_dbus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,

  output logic                timeout_o
);

  localparam int          BE_W    = DATA_W / 8;
  localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               arb_winner;
  logic               grant_update;
  logic               to_hit;

  logic               owner_req;
  logic               owner_we;
  logic [ADDR_W-1:0]  owner_addr;
  logic [BE_W-1:0]    owner_be;
  logic [DATA_W-1:0]  owner_wdata;
  logic [DATA_W-1:0]  dead_word;

  logic               ack;
  logic               resp;
  logic [DATA_W-1:0]  rdata;

  // Poison word repeated across the full data width.
  for (genvar i = 0; i < DATA_W; i++) begin : g_dead
    assign dead_word[i] = TIMEOUT_RDATA[i % 32];
  end

  udm_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({m1_req_i, m0_req_i}),
    .mode   (PRIO_MODE != 0),
    .update (grant_update),
    .grant  (owner_q),
    .winner (arb_winner)
  );

  always_comb begin
    if (owner_q == M_UDM) begin
      owner_req   = m1_req_i;
      owner_we    = m1_we_i;
      owner_addr  = m1_addr_i;
      owner_be    = m1_be_i;
      owner_wdata = m1_wdata_i;
    end else begin
      owner_req   = m0_req_i;
      owner_we    = m0_we_i;
      owner_addr  = m0_addr_i;
      owner_be    = m0_be_i;
      owner_wdata = m0_wdata_i;
    end
  end

  assign to_hit = (TIMEOUT != 0) && (state_q == RESP) && (cnt_q == CNT_W'(TO_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= M_CPU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_d = arb_winner;
          state_d = REQ;
        end
      end
      REQ: begin
        // An owner withdrawing before ack is abandoned without touching fairness state.
        if (!owner_req) begin
          state_d = IDLE;
        end else if (s_ack_i) begin
          grant_update = 1'b1;
          cnt_d        = '0;
          state_d      = owner_we ? IDLE : RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (s_resp_i || to_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever state the flops still hold.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    timeout_o = 1'b0;
    ack       = 1'b0;
    resp      = 1'b0;
    rdata     = '0;
    if (!rst_i) begin
      case (state_q)
        REQ: begin
          s_req_o   = owner_req;
          s_we_o    = owner_we;
          s_addr_o  = owner_addr;
          s_be_o    = owner_be;
          s_wdata_o = owner_wdata;
          ack       = owner_req && s_ack_i;
        end
        RESP: begin
          // A real response in the final timeout cycle still takes precedence.
          if (s_resp_i || to_hit) begin
            resp      = 1'b1;
            rdata     = s_resp_i ? s_rdata_i : dead_word;
            timeout_o = !s_resp_i;
          end
        end
        default: begin
        end
      endcase
    end
    m0_ack_o   = ack  && (owner_q == M_CPU);
    m1_ack_o   = ack  && (owner_q == M_UDM);
    m0_resp_o  = resp && (owner_q == M_CPU);
    m1_resp_o  = resp && (owner_q == M_UDM);
    m0_rdata_o = m0_resp_o ? rdata : '0;
    m1_rdata_o = m1_resp_o ? rdata : '0;
  end

endmodule
